leaf_out_sched: RTL and testbench

Output scheduler for a BFT leaf. Shares the single 49-bit leaf-to-BFT packet port among `NUM_OUT_PORTS` user output streams. Each stream uses a vld/ack handshake. Every accepted word is wrapped in a packet carrying destination leaf, destination port and a per-port sequence number. Injection is gated by per-port credits and by the BFT `resend` back-pressure. The block sits between the user kernel outputs and `dout_leaf_interface2bft` inside each `leaf_N`.

---
 rtl/leaf_pkt_pkg.sv | 32 +++
 rtl/rr_arbiter.sv | 33 +++
 rtl/leaf_out_sched.sv | 103 ++++++++++
 tb/tb_leaf_out_sched.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/leaf_pkt_pkg.sv
// Packet layout shared by the leaf output scheduler and its users.
// Latency: n/a (types, constants and an elaboration-time helper only).
// Backpressure: n/a.
package leaf_pkt_pkg;

  localparam int PAYLOAD_W = 32;
  localparam int LEAF_W    = 5;
  localparam int PORT_W    = 4;
  localparam int SEQ_W     = 7;
  localparam int PKT_W     = 1 + LEAF_W + PORT_W + SEQ_W + PAYLOAD_W;

  localparam int SEQ_LSB   = 0 + PAYLOAD_W;
  localparam int PORT_LSB  = SEQ_LSB + SEQ_W;
  localparam int LEAF_LSB  = PORT_LSB + PORT_W;
  localparam int VALID_BIT = LEAF_LSB + LEAF_W;

  typedef struct packed {
    logic                 vld;
    logic [LEAF_W-1:0]    leaf;
    logic [PORT_W-1:0]    port;
    logic [SEQ_W-1:0]     seq;
    logic [PAYLOAD_W-1:0] payload;
  } pkt_t;

  // True when the packet width is exactly the sum of its fields plus the valid bit.
  function automatic bit packet_bits_ok(input int leaf_w, input int port_w,
                                        input int addr_w, input int payload_w,
                                        input int packet_w);
    return packet_w == (1 + leaf_w + port_w + addr_w + payload_w);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick among requesters, searching upward from last_grant+1.
// Latency: purely combinational.
// Backpressure: none; requesters are pre-qualified by the caller.
module rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] last_grant,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx
);

  logic             found;
  logic [IDX_W-1:0] idx;

  // Walk the N positions after last_grant and take the first requester.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = '0;
    for (int k = 1; k <= N; k++) begin
      idx = IDX_W'((int'(last_grant) + k) % N);
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = idx;
      end
    end
  end

endmodule

// File: rtl/leaf_out_sched.sv
// Schedules user output streams onto the single leaf-to-BFT packet port.
// Latency: ack in grant cycle T, packet valid on dout in cycle T+1.
// Backpressure: resend or zero credit blocks a port's grant; ack stays low.
module leaf_out_sched
  import leaf_pkt_pkg::*;
#(
  parameter int NUM_OUT_PORTS = 4,
  parameter int PAYLOAD_BITS  = 32,
  parameter int NUM_LEAF_BITS = 5,
  parameter int NUM_PORT_BITS = 4,
  parameter int NUM_ADDR_BITS = 7,
  parameter int PACKET_BITS   = 49,
  parameter int CREDIT_BITS   = 8,
  parameter int INIT_CREDIT   = 64
) (
  input  logic                                                 clk,
  input  logic                                                 reset,
  input  logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0]                din_leaf_user2interface,
  input  logic [NUM_OUT_PORTS-1:0]                             vld_user2interface,
  output logic [NUM_OUT_PORTS-1:0]                             ack_interface2user,
  input  logic [NUM_OUT_PORTS*(NUM_LEAF_BITS+NUM_PORT_BITS)-1:0] dest_cfg,
  input  logic                                                 credit_ret_vld,
  input  logic [NUM_PORT_BITS-1:0]                             credit_ret_port,
  input  logic [CREDIT_BITS-1:0]                               credit_ret_amt,
  input  logic                                                 resend,
  output logic [PACKET_BITS-1:0]                               dout_leaf_interface2bft
);

  localparam int IDX_W  = $clog2(NUM_OUT_PORTS);
  localparam int DEST_W = NUM_LEAF_BITS + NUM_PORT_BITS;

  if (!packet_bits_ok(NUM_LEAF_BITS, NUM_PORT_BITS, NUM_ADDR_BITS,
                      PAYLOAD_BITS, PACKET_BITS)) begin : g_bad_width
    $error("PACKET_BITS does not match the sum of the packet fields");
  end

  logic [PAYLOAD_BITS-1:0]  din_arr    [NUM_OUT_PORTS];
  logic [DEST_W-1:0]        dest_arr   [NUM_OUT_PORTS];
  logic [CREDIT_BITS-1:0]   credit     [NUM_OUT_PORTS];
  logic [CREDIT_BITS-1:0]   credit_nxt [NUM_OUT_PORTS];
  logic [NUM_ADDR_BITS-1:0] seq        [NUM_OUT_PORTS];
  logic [NUM_OUT_PORTS-1:0] req;
  logic [NUM_OUT_PORTS-1:0] grant;
  logic [IDX_W-1:0]         grant_idx;
  logic [IDX_W-1:0]         last_grant;
  logic [CREDIT_BITS:0]     sum;

  for (genvar i = 0; i < NUM_OUT_PORTS; i++) begin : g_port
    assign din_arr[i]  = din_leaf_user2interface[i*PAYLOAD_BITS +: PAYLOAD_BITS];
    assign dest_arr[i] = dest_cfg[i*DEST_W +: DEST_W];
    assign req[i]      = vld_user2interface[i] && (credit[i] != '0) && !resend;
  end

  rr_arbiter #(.N(NUM_OUT_PORTS), .IDX_W(IDX_W)) u_arb (
    .req        (req),
    .last_grant (last_grant),
    .grant      (grant),
    .grant_idx  (grant_idx)
  );

  // Ack is the grant itself, held off while reset is asserted.
  assign ack_interface2user = reset ? grant : '0;

  // Next credit per port: spend on grant, add a matching return, saturate at max.
  always_comb begin
    sum = '0;
    for (int i = 0; i < NUM_OUT_PORTS; i++) begin
      sum = {1'b0, credit[i]} - (CREDIT_BITS+1)'(grant[i]);
      if (credit_ret_vld && (credit_ret_port == NUM_PORT_BITS'(i)))
        sum = sum + {1'b0, credit_ret_amt};
      credit_nxt[i] = sum[CREDIT_BITS] ? {CREDIT_BITS{1'b1}} : sum[CREDIT_BITS-1:0];
    end
  end

  // Per-port credit and sequence state, plus the round-robin pointer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_OUT_PORTS; i++) begin
        credit[i] <= CREDIT_BITS'(INIT_CREDIT);
        seq[i]    <= '0;
      end
      last_grant <= IDX_W'(NUM_OUT_PORTS - 1);
    end else begin
      for (int i = 0; i < NUM_OUT_PORTS; i++) begin
        credit[i] <= credit_nxt[i];
        if (grant[i]) seq[i] <= seq[i] + 1'b1;
      end
      if (|grant) last_grant <= grant_idx;
    end
  end

  // Output register: load the granted packet, otherwise drop only the valid bit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dout_leaf_interface2bft <= '0;
    end else if (|grant) begin
      dout_leaf_interface2bft <= {1'b1, dest_arr[grant_idx], seq[grant_idx], din_arr[grant_idx]};
    end else begin
      dout_leaf_interface2bft[PACKET_BITS-1] <= 1'b0;
    end
  end

endmodule

// File: tb/tb_leaf_out_sched.sv
// Randomized bench for leaf_out_sched against a queue-free behavioural model.
// Latency: ack checked before the edge, dout checked 1 unit after it.
// Backpressure: resend and credit exhaustion exercised directly and randomly.
module tb_leaf_out_sched;
  import leaf_pkt_pkg::*;

  localparam int N  = 4;
  localparam int PW = 32;
  localparam int DW = 9;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic [N*PW-1:0] din = '0;
  logic [N-1:0]    vld = '0;
  logic [N-1:0]    ack;
  logic [N*DW-1:0] dest_cfg = '0;
  logic            credit_ret_vld = 1'b0;
  logic [3:0]      credit_ret_port = '0;
  logic [7:0]      credit_ret_amt = '0;
  logic            resend = 1'b0;
  logic [48:0]     dout;

  int checks = 0;
  int errors = 0;

  // Reference model state: what the scheduler should hold, in plain integers.
  int          m_credit [N];
  int          m_seq    [N];
  int          m_last;
  logic [48:0] m_dout;

  leaf_out_sched dut (
    .clk                     (clk),
    .reset                   (reset),
    .din_leaf_user2interface (din),
    .vld_user2interface      (vld),
    .ack_interface2user      (ack),
    .dest_cfg                (dest_cfg),
    .credit_ret_vld          (credit_ret_vld),
    .credit_ret_port         (credit_ret_port),
    .credit_ret_amt          (credit_ret_amt),
    .resend                  (resend),
    .dout_leaf_interface2bft (dout)
  );

  always #5 clk = ~clk;

  function automatic void m_reset();
    for (int p = 0; p < N; p++) begin
      m_credit[p] = 64;
      m_seq[p]    = 0;
    end
    m_last = N - 1;
    m_dout = '0;
  endfunction

  // Which port the rules say wins this cycle, or -1 for none.
  function automatic int m_pick();
    int p;
    if (resend) return -1;
    for (int k = 1; k <= N; k++) begin
      p = (m_last + k) % N;
      if (vld[p] && m_credit[p] > 0) return p;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] oh(input int g);
    logic [N-1:0] r;
    r = '0;
    if (g >= 0) r[g] = 1'b1;
    return r;
  endfunction

  // Apply one clock edge to the model given the winner g.
  function automatic void m_commit(input int g);
    int c;
    logic [6:0] s;
    if (g >= 0) begin
      s = 7'(m_seq[g]);
      m_dout = {1'b1, dest_cfg[g*DW +: DW], s, din[g*PW +: PW]};
      m_seq[g] = (m_seq[g] + 1) % 128;
      m_last = g;
    end else begin
      m_dout[48] = 1'b0;
    end
    for (int p = 0; p < N; p++) begin
      c = m_credit[p] - ((p == g) ? 1 : 0);
      if (credit_ret_vld && int'(credit_ret_port) == p) c = c + int'(credit_ret_amt);
      if (c > 255) c = 255;
      m_credit[p] = c;
    end
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    vld = '0;
    resend = 1'b0;
    credit_ret_vld = 1'b0;
    dest_cfg = {$urandom, $urandom};
    @(negedge clk);
    m_reset();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    vld = '1;
    din = {$urandom, $urandom, $urandom, $urandom};
    #1;
    checks++;
    if (ack !== 4'b0) begin errors++; $display("FAIL reset_ack got %b want 0000", ack); end
    checks++;
    if (dout !== 49'b0) begin errors++; $display("FAIL reset_dout got %h want 0", dout); end
    do_reset();
  endtask

  task automatic test_single_port();
    logic [31:0] w [3];
    int g;
    pkt_t p;
    do_reset();
    vld = 4'b0001;
    for (int c = 0; c < 4; c++) begin
      if (c == 3) vld = '0;
      if (c < 3) begin w[c] = $urandom; din[31:0] = w[c]; end
      #1; g = m_pick();
      checks++;
      if (ack !== oh(g) || (c < 3 && ack !== 4'b0001))
        begin errors++; $display("FAIL single_ack cyc %0d got %b want %b", c, ack, oh(g)); end
      m_commit(g);
      @(posedge clk); #1;
      p = dout;
      checks++;
      if (dout !== m_dout || (c < 3 && (p.seq !== 7'(c) || p.payload !== w[c] || !p.vld)))
        begin errors++; $display("FAIL single_dout cyc %0d got %h want %h", c, dout, m_dout); end
      @(negedge clk);
    end
  endtask

  task automatic test_all_ports();
    int g;
    do_reset();
    vld = '1;
    for (int c = 0; c < 8; c++) begin
      din = {$urandom, $urandom, $urandom, $urandom};
      #1; g = m_pick();
      checks++;
      if (ack !== oh(g) || ack !== oh(c % N))
        begin errors++; $display("FAIL rr_ack cyc %0d got %b want %b", c, ack, oh(c % N)); end
      m_commit(g);
      @(posedge clk); #1;
      checks++;
      if (dout !== m_dout || dout[38:32] !== 7'(c / N))
        begin errors++; $display("FAIL rr_dout cyc %0d got %h want %h", c, dout, m_dout); end
      @(negedge clk);
    end
  endtask

  task automatic test_credit();
    int g;
    int grants;
    grants = 0;
    do_reset();
    vld = 4'b0010;
    for (int c = 0; c < 71; c++) begin
      din = {$urandom, $urandom, $urandom, $urandom};
      credit_ret_vld  = (c == 66 || c == 67);
      credit_ret_port = (c == 66) ? 4'd1 : 4'd9;
      credit_ret_amt  = (c == 66) ? 8'd1 : 8'd5;
      #1; g = m_pick();
      if (ack[1] === 1'b1) grants++;
      checks++;
      if (ack !== oh(g))
        begin errors++; $display("FAIL credit_ack cyc %0d got %b want %b", c, ack, oh(g)); end
      m_commit(g);
      @(posedge clk); #1;
      checks++;
      if (dout !== m_dout)
        begin errors++; $display("FAIL credit_dout cyc %0d got %h want %h", c, dout, m_dout); end
      @(negedge clk);
    end
    credit_ret_vld = 1'b0;
    checks++;
    if (grants != 65) begin errors++; $display("FAIL credit_total got %0d want 65", grants); end
  endtask

  task automatic test_resend();
    int g;
    do_reset();
    vld = 4'b0100;
    for (int c = 0; c < 10; c++) begin
      din = {$urandom, $urandom, $urandom, $urandom};
      resend = (c >= 3 && c <= 5);
      #1; g = m_pick();
      checks++;
      if (ack !== oh(g) || (resend && ack !== 4'b0))
        begin errors++; $display("FAIL resend_ack cyc %0d got %b want %b", c, ack, oh(g)); end
      m_commit(g);
      @(posedge clk); #1;
      checks++;
      if (dout !== m_dout)
        begin errors++; $display("FAIL resend_dout cyc %0d got %h want %h", c, dout, m_dout); end
      @(negedge clk);
    end
    resend = 1'b0;
  endtask

  task automatic test_seq_wrap();
    int g;
    do_reset();
    vld = 4'b1000;
    credit_ret_vld = 1'b1; credit_ret_port = 4'd3; credit_ret_amt = 8'd1;
    for (int c = 0; c < 130; c++) begin
      din = {$urandom, $urandom, $urandom, $urandom};
      #1; g = m_pick();
      checks++;
      if (ack !== oh(g))
        begin errors++; $display("FAIL wrap_ack cyc %0d got %b want %b", c, ack, oh(g)); end
      m_commit(g);
      @(posedge clk); #1;
      checks++;
      if (dout !== m_dout || dout[38:32] !== 7'(c % 128))
        begin errors++; $display("FAIL wrap_dout cyc %0d got %h want %h", c, dout, m_dout); end
      @(negedge clk);
    end
    credit_ret_vld = 1'b0;
  endtask

  task automatic test_saturation();
    int g;
    int grants;
    grants = 0;
    do_reset();
    for (int c = 0; c < 259; c++) begin
      credit_ret_vld = (c == 0); credit_ret_port = 4'd0; credit_ret_amt = 8'd250;
      vld = (c == 0) ? 4'b0000 : 4'b0001;
      din = {$urandom, $urandom, $urandom, $urandom};
      #1; g = m_pick();
      if (ack[0] === 1'b1) grants++;
      checks++;
      if (ack !== oh(g))
        begin errors++; $display("FAIL sat_ack cyc %0d got %b want %b", c, ack, oh(g)); end
      m_commit(g);
      @(posedge clk); #1;
      checks++;
      if (dout !== m_dout)
        begin errors++; $display("FAIL sat_dout cyc %0d got %h want %h", c, dout, m_dout); end
      @(negedge clk);
    end
    credit_ret_vld = 1'b0;
    checks++;
    if (grants != 255) begin errors++; $display("FAIL sat_total got %0d want 255", grants); end
  endtask

  task automatic test_random();
    int g;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      din = {$urandom, $urandom, $urandom, $urandom};
      vld = 4'($urandom);
      resend = ($urandom_range(0, 3) == 0);
      credit_ret_vld  = ($urandom_range(0, 4) == 0);
      credit_ret_port = 4'($urandom_range(0, 5));
      credit_ret_amt  = 8'($urandom_range(0, 3));
      #1; g = m_pick();
      checks++;
      if (ack !== oh(g))
        begin errors++; $display("FAIL rand_ack cyc %0d got %b want %b", c, ack, oh(g)); end
      m_commit(g);
      @(posedge clk); #1;
      checks++;
      if (dout !== m_dout)
        begin errors++; $display("FAIL rand_dout cyc %0d got %h want %h", c, dout, m_dout); end
      @(negedge clk);
    end
    resend = 1'b0;
    credit_ret_vld = 1'b0;
  endtask

  task automatic test_reset_midstream();
    int g;
    do_reset();
    vld = '1;
    for (int c = 0; c < 9; c++) begin
      din = {$urandom, $urandom, $urandom, $urandom};
      if (c == 5) begin
        #2; reset = 1'b0; #1;
        checks++;
        if (ack !== 4'b0 || dout !== 49'b0)
          begin errors++; $display("FAIL midreset got ack %b dout %h want 0 0", ack, dout); end
        m_reset();
        @(negedge clk);
        reset = 1'b1;
      end
      #1; g = m_pick();
      checks++;
      if (ack !== oh(g) || (c == 5 && ack !== 4'b0001))
        begin errors++; $display("FAIL mid_ack cyc %0d got %b want %b", c, ack, oh(g)); end
      m_commit(g);
      @(posedge clk); #1;
      checks++;
      if (dout !== m_dout || (c == 5 && dout[38:32] !== 7'd0))
        begin errors++; $display("FAIL mid_dout cyc %0d got %h want %h", c, dout, m_dout); end
      @(negedge clk);
    end
  endtask

  initial begin
    m_reset();
    test_reset();
    test_single_port();
    test_all_ports();
    test_credit();
    test_resend();
    test_seq_wrap();
    test_saturation();
    test_random();
    test_reset_midstream();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
